ip2_scan_seq: RTL and testbench
===============================

IP2_SCAN_SEQ -- requirements
Module: ip2_scan_seq

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 768, scan-chain length in bits per lane.
REQ-002 SHALL have parameter N_CH, default 4, number of parallel scan lanes.
REQ-003 SHALL have parameter CW, default 6, slot-counter width.
REQ-004 clk  in  1  FM clock, 400 MHz, sole clock.
REQ-005 reset_not  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  block select; low forces IDLE synchronously.
REQ-007 clk_counter  in  CW  free-running slot counter.
REQ-008 test_delay  in  CW  slot phase; "tick" = (clk_counter==test_delay).
REQ-009 test_mask_reset_not  in  1  1 = suppress the ASIC reset pulse.
REQ-010 start_re  in  1  one-cycle start request.
REQ-011 mode  in  1  0 = shift-only; 1 = capture-then-shift.
REQ-012 n_pass  in  8  number of full-chain passes; 0 is treated as 1.
REQ-013 abort  in  1  terminate the sequence at the next tick.
REQ-014 i_scanchain_bit0  in  N_CH  LSB of each external pattern register.
REQ-015 i_scan_out  in  N_CH  ASIC scan outputs, used for readback.
REQ-016 o_scanchain_reg_load / o_scanchain_reg_shift  out  1 each  pattern-register load / shift-right requests.
REQ-017 o_status_done  out  1  sticky completion flag.
REQ-018 o_state  out  3  current FSM state.
REQ-019 o_reset_not / o_scan_load  out  1 each  ASIC reset (active-low) / mode (0 = shift, 1 = load-comparators).
REQ-020 o_scan_in  out  N_CH  serial data to the ASIC.
REQ-021 o_err_cnt  out  16  readback mismatch count, saturating.

Function
REQ-022 States SHALL be: IDLE=0, DELAY=1, RESET=2, CAPTURE=3, SHIFT0=4, SHIFT=5, DONE=6; encoding 7 returns to IDLE.
REQ-023 IDLE: start_re -> DELAY; o_status_done SHALL hold; o_scan_load=1, o_reset_not=1, o_scan_in=0.
REQ-024 DELAY: o_scanchain_reg_load=1; on tick -> RESET, o_scan_load<=0, o_reset_not<=test_mask_reset_not, o_status_done<=0, pass and shift counters cleared.
REQ-025 RESET: o_reset_not SHALL stay at test_mask_reset_not until tick; on tick o_reset_not<=1, o_scan_in<=i_scanchain_bit0, then -> CAPTURE if mode=1, else -> SHIFT0.
REQ-026 CAPTURE: o_scan_load=1 for exactly one slot (from tick to tick); on tick o_scan_load<=0 -> SHIFT0.
REQ-027 SHIFT0/SHIFT: o_scanchain_reg_shift SHALL pulse for one cycle when clk_counter==(test_delay-2) mod 2^CW, giving two-cycle latency to the updated bit0; o_scan_in<=i_scanchain_bit0 every cycle; SHIFT0 -> SHIFT on tick.
REQ-028 The internal shift counter SHALL increment on each tick in SHIFT; at CHAIN_LEN-1 it SHALL wrap to 0 and increment the pass counter.
REQ-029 When the pass counter reaches max(n_pass,1), the FSM SHALL go to DONE, o_scan_load<=1, o_status_done<=1; otherwise it SHALL continue shifting with no gap.
REQ-030 abort SHALL be sampled in DELAY, RESET, CAPTURE, SHIFT0 or SHIFT; at the next tick the FSM SHALL go to DONE with o_status_done=1, o_reset_not=1, o_scan_load=1.
REQ-031 DONE: a single cycle, then -> IDLE; start_re received in DONE SHALL be ignored.
REQ-032 test_delay in {0,1} SHALL wrap the shift-pulse compare modulo 2^CW; there is no special case.
REQ-033 mode, n_pass and test_mask_reset_not SHALL be latched in IDLE on start_re; later changes SHALL have no effect until the next start.

Reset
REQ-034 On reset_not low: o_state=IDLE, o_reset_not=1, o_scan_load=1, o_scan_in=0, o_scanchain_reg_load=0, o_scanchain_reg_shift=0, o_status_done=0, o_err_cnt=0, all counters 0; reset mid-sequence SHALL abandon the sequence immediately.

Configuration
REQ-035 With IP2_SCAN_SEQ_READBACK_EN defined, in SHIFT at each tick from pass 2 onward, each lane where i_scan_out differs from the bit shifted one pass earlier SHALL add 1 to o_err_cnt (saturating at 0xFFFF); o_err_cnt SHALL clear on DELAY entry.
REQ-036 Without IP2_SCAN_SEQ_READBACK_EN, o_err_cnt SHALL be tied to 0 and i_scan_out SHALL be unused.

Structure
REQ-037 The FSM state enum and the scan-mode enum (SHIFT_REG=0, LOAD_COMP=1) SHALL live in shared package ip2_pkg.
REQ-038 The readback comparator SHALL be a sub-module ip2_scan_cmp (per-lane delay line of CHAIN_LEN bits plus the saturating counter).

Verification
REQ-039 CHAIN_LEN=8, N_CH=1, n_pass=1, mode=0, test_delay=5 -> exactly 8 shift pulses, each at clk_counter=3, then DONE and o_status_done=1.
REQ-040 test_mask_reset_not=0 -> o_reset_not low for exactly one slot (64 cycles); with mask=1 -> o_reset_not never low.
REQ-041 mode=1 -> o_scan_load high for 64 cycles between RESET and SHIFT0; n_pass=3 -> 24 shift pulses.
REQ-042 abort asserted after the 4th shift -> DONE at the next tick, 4 or 5 pulses total, o_status_done=1.
REQ-043 test_delay=1 -> shift pulse occurs at clk_counter=63; reset_not dropped in SHIFT -> all outputs at reset values in the same cycle.
REQ-044 READBACK_EN, loopback i_scan_out=o_scan_in delayed CHAIN_LEN, n_pass=2 -> o_err_cnt=0; forcing one lane's bit flipped -> o_err_cnt=1.

Source files
------------

// File: rtl/ip2_pkg.sv
// Shared types for the IP2 scan sequencer: FSM state encoding, scan-mode
// encoding and the saturating add used by the readback error counter.
package ip2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DELAY   = 3'd1,
        ST_RESET   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SHIFT0  = 3'd4,
        ST_SHIFT   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    typedef enum logic {
        SHIFT_REG = 1'b0,
        LOAD_COMP = 1'b1
    } scan_mode_t;

    localparam int ERR_W = 16;

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                 input logic [ERR_W-1:0] b);
        logic [ERR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/ip2_scan_cmp.sv
// Readback comparator: per-lane CHAIN_LEN-deep history of shifted bits, compared
// against the ASIC scan outputs one full pass later, with a saturating error count.
module ip2_scan_cmp
    import ip2_pkg::*;
#(
    parameter int CHAIN_LEN = 768,
    parameter int N_CH      = 4
) (
    input  logic             clk,
    input  logic             reset_not,
    input  logic             clear,
    input  logic             push,
    input  logic             check,
    input  logic [N_CH-1:0]  din,
    input  logic [N_CH-1:0]  obs,
    output logic [ERR_W-1:0] err_cnt
);

    logic [N_CH-1:0]  past;
    logic [ERR_W-1:0] n_bad;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        logic [CHAIN_LEN-1:0] line;

        always_ff @(posedge clk or negedge reset_not) begin
            if (!reset_not)
                line <= '0;
            else if (push)
                line <= (line << 1) | CHAIN_LEN'(din[g]);
        end

        // Oldest entry is the bit pushed exactly CHAIN_LEN shifts ago.
        assign past[g] = line[CHAIN_LEN-1];
    end

    always_comb begin
        n_bad = '0;
        for (int i = 0; i < N_CH; i++)
            n_bad = n_bad + ERR_W'(obs[i] ^ past[i]);
    end

    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not)
            err_cnt <= '0;
        else if (clear)
            err_cnt <= '0;
        else if (check)
            err_cnt <= sat_add(err_cnt, n_bad);
    end

endmodule

// File: rtl/ip2_scan_seq.sv
// Scan-chain sequencer: delay, ASIC reset, optional capture, then N full-chain passes.
// Define IP2_SCAN_SEQ_READBACK_EN to enable readback error counting on i_scan_out.
module ip2_scan_seq
    import ip2_pkg::*;
#(
    parameter int CHAIN_LEN = 768,
    parameter int N_CH      = 4,
    parameter int CW        = 6
) (
    input  logic            clk,
    input  logic            reset_not,
    input  logic            enable,
    input  logic [CW-1:0]   clk_counter,
    input  logic [CW-1:0]   test_delay,
    input  logic            test_mask_reset_not,
    input  logic            start_re,
    input  logic            mode,
    input  logic [7:0]      n_pass,
    input  logic            abort,
    input  logic [N_CH-1:0] i_scanchain_bit0,
    input  logic [N_CH-1:0] i_scan_out,
    output logic            o_scanchain_reg_load,
    output logic            o_scanchain_reg_shift,
    output logic            o_status_done,
    output logic [2:0]      o_state,
    output logic            o_reset_not,
    output logic            o_scan_load,
    output logic [N_CH-1:0] o_scan_in,
    output logic [15:0]     o_err_cnt
);

    localparam int SC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    state_t          state, state_nxt;
    scan_mode_t      mode_q;
    logic [7:0]      n_eff;
    logic            mask_q;
    logic            abort_pend;
    logic [SC_W-1:0] shift_cnt;
    logic [7:0]      pass_cnt;

    logic            tick, shifting, active, abort_any, last_bit, pass_end, enter_done;
    logic [CW-1:0]   td_m2;

    assign tick     = (clk_counter == test_delay);
    assign td_m2    = test_delay - CW'(2);
    assign shifting = (state == ST_SHIFT0) || (state == ST_SHIFT);
    assign active   = (state == ST_DELAY) || (state == ST_RESET) ||
                      (state == ST_CAPTURE) || shifting;
    assign abort_any = active && (abort || abort_pend);
    assign last_bit = (shift_cnt == SC_W'(CHAIN_LEN-1));
    // The SHIFT0 tick clocks the first chain bit, so it counts toward the pass.
    assign pass_end = shifting && tick && last_bit && ((pass_cnt + 8'd1) == n_eff);
    assign enter_done = enable && (state != ST_DONE) && (state_nxt == ST_DONE);

    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start_re) state_nxt = ST_DELAY;
                ST_DELAY:   if (tick) state_nxt = abort_any ? ST_DONE : ST_RESET;
                ST_RESET:   if (tick) state_nxt = abort_any ? ST_DONE :
                                                  (mode_q == LOAD_COMP) ? ST_CAPTURE : ST_SHIFT0;
                ST_CAPTURE: if (tick) state_nxt = abort_any ? ST_DONE : ST_SHIFT0;
                ST_SHIFT0:  if (tick) state_nxt = (abort_any || pass_end) ? ST_DONE : ST_SHIFT;
                ST_SHIFT:   if (tick && (abort_any || pass_end)) state_nxt = ST_DONE;
                ST_DONE:    state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_scanchain_reg_load  = (state == ST_DELAY);
        // Two cycles ahead of the tick so the refreshed bit0 is ready when sampled.
        o_scanchain_reg_shift = shifting && (clk_counter == td_m2);
    end

    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            o_reset_not   <= 1'b1;
            o_scan_load   <= 1'b1;
            o_scan_in     <= '0;
            o_status_done <= 1'b0;
            mode_q        <= SHIFT_REG;
            n_eff         <= 8'd1;
            mask_q        <= 1'b1;
            abort_pend    <= 1'b0;
            shift_cnt     <= '0;
            pass_cnt      <= '0;
        end else if (!enable) begin
            o_reset_not <= 1'b1;
            o_scan_load <= 1'b1;
            o_scan_in   <= '0;
            abort_pend  <= 1'b0;
            shift_cnt   <= '0;
            pass_cnt    <= '0;
        end else begin
            if (abort && active)
                abort_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    o_reset_not <= 1'b1;
                    o_scan_load <= 1'b1;
                    o_scan_in   <= '0;
                    abort_pend  <= 1'b0;
                    if (start_re) begin
                        mode_q <= scan_mode_t'(mode);
                        n_eff  <= (n_pass == 8'd0) ? 8'd1 : n_pass;
                        mask_q <= test_mask_reset_not;
                    end
                end
                ST_DELAY: if (tick && !abort_any) begin
                    o_scan_load   <= 1'b0;
                    o_reset_not   <= mask_q;
                    o_status_done <= 1'b0;
                    shift_cnt     <= '0;
                    pass_cnt      <= '0;
                end
                ST_RESET: if (tick && !abort_any) begin
                    o_reset_not <= 1'b1;
                    o_scan_in   <= i_scanchain_bit0;
                    o_scan_load <= (mode_q == LOAD_COMP);
                end
                ST_CAPTURE: if (tick && !abort_any) o_scan_load <= 1'b0;
                ST_SHIFT0, ST_SHIFT: begin
                    o_scan_in <= i_scanchain_bit0;
                    if (tick && !abort_any) begin
                        if (last_bit) begin
                            shift_cnt <= '0;
                            pass_cnt  <= pass_cnt + 8'd1;
                        end else begin
                            shift_cnt <= shift_cnt + SC_W'(1);
                        end
                    end
                end
                default: begin
                    o_scan_in  <= '0;
                    abort_pend <= 1'b0;
                end
            endcase
            if (enter_done) begin
                o_status_done <= 1'b1;
                o_reset_not   <= 1'b1;
                o_scan_load   <= 1'b1;
                o_scan_in     <= '0;
                abort_pend    <= 1'b0;
            end
        end
    end

    assign o_state = state;

`ifdef IP2_SCAN_SEQ_READBACK_EN
    ip2_scan_cmp #(
        .CHAIN_LEN (CHAIN_LEN),
        .N_CH      (N_CH)
    ) u_cmp (
        .clk       (clk),
        .reset_not (reset_not),
        .clear     (enable && (state == ST_IDLE) && start_re),
        .push      (enable && shifting && tick),
        .check     (enable && (state == ST_SHIFT) && tick && (pass_cnt != 8'd0)),
        .din       (o_scan_in),
        .obs       (i_scan_out),
        .err_cnt   (o_err_cnt)
    );
`else
    logic unused_scan_out;
    assign unused_scan_out = ^i_scan_out;
    assign o_err_cnt       = '0;
`endif

endmodule

// File: tb/tb_ip2_scan_seq.sv
// Directed bench for ip2_scan_seq: pulse counts/phase, reset slot, capture slot,
// abort, latching, enable, async reset and readback error count.
module tb_ip2_scan_seq;

    localparam int CL = 8;
    localparam int NC = 2;
`ifdef IP2_SCAN_SEQ_READBACK_EN
    localparam int FLIP_ERR = 1;
`else
    localparam int FLIP_ERR = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_not, enable, test_mask_reset_not, start_re, mode, abort;
    logic [5:0]    clk_counter, test_delay;
    logic [7:0]    n_pass;
    logic [NC-1:0] i_scanchain_bit0, i_scan_out, o_scan_in, flip;
    logic          o_scanchain_reg_load, o_scanchain_reg_shift, o_status_done;
    logic          o_reset_not, o_scan_load;
    logic [2:0]    o_state;
    logic [15:0]   o_err_cnt;

    int total = 0, bad = 0;
    int pulses = 0, ph_bad = 0, rst_low = 0, cap_load = 0, sin_bad = 0, ld_bad = 0;
    logic [5:0] exp_ph = 6'd3;

    always #5 clk = ~clk;

    assign i_scan_out = o_scan_in ^ flip;

    ip2_scan_seq #(.CHAIN_LEN(CL), .N_CH(NC), .CW(6)) dut (
        .clk                   (clk),
        .reset_not             (reset_not),
        .enable                (enable),
        .clk_counter           (clk_counter),
        .test_delay            (test_delay),
        .test_mask_reset_not   (test_mask_reset_not),
        .start_re              (start_re),
        .mode                  (mode),
        .n_pass                (n_pass),
        .abort                 (abort),
        .i_scanchain_bit0      (i_scanchain_bit0),
        .i_scan_out            (i_scan_out),
        .o_scanchain_reg_load  (o_scanchain_reg_load),
        .o_scanchain_reg_shift (o_scanchain_reg_shift),
        .o_status_done         (o_status_done),
        .o_state               (o_state),
        .o_reset_not           (o_reset_not),
        .o_scan_load           (o_scan_load),
        .o_scan_in             (o_scan_in),
        .o_err_cnt             (o_err_cnt)
    );

    initial begin
        clk_counter = 6'd0;
        forever begin
            @(posedge clk);
            #1 clk_counter = clk_counter + 6'd1;
        end
    end

    always @(negedge clk) begin
        if (o_scanchain_reg_shift === 1'b1) begin
            pulses++;
            if (clk_counter !== exp_ph) ph_bad++;
        end
        if (o_reset_not === 1'b0) rst_low++;
        if (o_scan_load === 1'b1 && o_state === 3'd3) cap_load++;
        if (o_state === 3'd5 && o_scan_in !== i_scanchain_bit0) sin_bad++;
        if (o_scanchain_reg_load !== (o_state === 3'd1)) ld_bad++;
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (o_state !== s && n < 5000) begin
            nxt();
            n++;
        end
        chk(tag, 32'(o_state), 32'(s));
    endtask

    task automatic wait_pulses(input int p, input string tag);
        int n = 0;
        while (pulses < p && n < 5000) begin
            nxt();
            n++;
        end
        chk(tag, 32'(pulses >= p), 32'd1);
    endtask

    task automatic run(input logic m, input logic [7:0] np, input logic mk, input logic [5:0] td);
        mode = m; n_pass = np; test_mask_reset_not = mk; test_delay = td;
        exp_ph = td - 6'd2;
        pulses = 0; ph_bad = 0; rst_low = 0; cap_load = 0; sin_bad = 0; ld_bad = 0;
        start_re = 1'b1;
        nxt();
        start_re = 1'b0;
    endtask

    initial begin
        reset_not = 1'b0; enable = 1'b1; test_mask_reset_not = 1'b1; start_re = 1'b0;
        mode = 1'b0; abort = 1'b0; test_delay = 6'd5; n_pass = 8'd1;
        i_scanchain_bit0 = 2'b10; flip = '0;
        repeat (3) nxt();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_reset_not", 32'(o_reset_not), 32'd1);
        chk("rst_scan_load", 32'(o_scan_load), 32'd1);
        chk("rst_scan_in", 32'(o_scan_in), 32'd0);
        chk("rst_reg_load", 32'(o_scanchain_reg_load), 32'd0);
        chk("rst_reg_shift", 32'(o_scanchain_reg_shift), 32'd0);
        chk("rst_done", 32'(o_status_done), 32'd0);
        chk("rst_err", 32'(o_err_cnt), 32'd0);
        reset_not = 1'b1;
        nxt();

        // Basic single pass, shift-only, reset masked.
        run(1'b0, 8'd1, 1'b1, 6'd5);
        chk("a_delay", 32'(o_state), 32'd1);
        chk("a_reg_load", 32'(o_scanchain_reg_load), 32'd1);
        wait_state(3'd6, "a_reach_done");
        chk("a_pulses", 32'(pulses), 32'd8);
        chk("a_phase", 32'(ph_bad), 32'd0);
        chk("a_done_flag", 32'(o_status_done), 32'd1);
        chk("a_rst_low", 32'(rst_low), 32'd0);
        chk("a_scan_in", 32'(sin_bad), 32'd0);
        start_re = 1'b1;
        nxt();
        start_re = 1'b0;
        chk("a_to_idle", 32'(o_state), 32'd0);
        nxt();
        chk("a_start_ignored", 32'(o_state), 32'd0);
        chk("a_done_hold", 32'(o_status_done), 32'd1);

        // Capture mode, three passes, reset pulse; inputs changed after start must not matter.
        run(1'b1, 8'd3, 1'b0, 6'd5);
        mode = 1'b0; n_pass = 8'd1; test_mask_reset_not = 1'b1;
        chk("b_done_held", 32'(o_status_done), 32'd1);
        wait_state(3'd2, "b_reach_reset");
        chk("b_done_clr", 32'(o_status_done), 32'd0);
        chk("b_reset_low", 32'(o_reset_not), 32'd0);
        chk("b_scan_load0", 32'(o_scan_load), 32'd0);
        wait_state(3'd6, "b_reach_done");
        chk("b_pulses", 32'(pulses), 32'd24);
        chk("b_rst_slot", 32'(rst_low), 32'd64);
        chk("b_cap_slot", 32'(cap_load), 32'd64);
        chk("b_phase", 32'(ph_bad), 32'd0);
        chk("b_reg_load", 32'(ld_bad), 32'd0);
        nxt();

        // n_pass=0 behaves as one pass; abort after the 4th shift.
        run(1'b0, 8'd0, 1'b1, 6'd5);
        wait_pulses(4, "c_wait4");
        abort = 1'b1;
        nxt();
        abort = 1'b0;
        wait_state(3'd6, "c_reach_done");
        chk("c_pulses", 32'(pulses == 4 || pulses == 5), 32'd1);
        chk("c_done_flag", 32'(o_status_done), 32'd1);
        chk("c_reset_not", 32'(o_reset_not), 32'd1);
        chk("c_scan_load", 32'(o_scan_load), 32'd1);
        nxt();

        // enable low forces IDLE.
        run(1'b0, 8'd1, 1'b1, 6'd5);
        enable = 1'b0;
        nxt();
        chk("e_idle", 32'(o_state), 32'd0);
        chk("e_scan_load", 32'(o_scan_load), 32'd1);
        enable = 1'b1;
        nxt();
        chk("e_stay_idle", 32'(o_state), 32'd0);

        // test_delay=1 wraps the shift phase to 63; then async reset mid-shift.
        run(1'b0, 8'd1, 1'b1, 6'd1);
        wait_pulses(3, "d_wait3");
        chk("d_in_shift", 32'(o_state), 32'd5);
        chk("d_phase63", 32'(ph_bad), 32'd0);
        reset_not = 1'b0;
        #1;
        chk("d_state", 32'(o_state), 32'd0);
        chk("d_reset_not", 32'(o_reset_not), 32'd1);
        chk("d_scan_load", 32'(o_scan_load), 32'd1);
        chk("d_scan_in", 32'(o_scan_in), 32'd0);
        chk("d_reg_shift", 32'(o_scanchain_reg_shift), 32'd0);
        chk("d_reg_load", 32'(o_scanchain_reg_load), 32'd0);
        nxt();
        reset_not = 1'b1;
        nxt();

        // Loopback readback: one flipped bit in pass 2, then a clean run.
        run(1'b0, 8'd2, 1'b1, 6'd5);
        wait_pulses(10, "r_wait_pass2");
        begin
            int n = 0;
            while (clk_counter !== 6'd5 && n < 100) begin
                nxt();
                n++;
            end
        end
        flip = 2'b01;
        nxt();
        flip = '0;
        wait_state(3'd6, "r_reach_done");
        chk("r_err_flip", 32'(o_err_cnt), 32'(FLIP_ERR));
        nxt();
        run(1'b0, 8'd2, 1'b1, 6'd5);
        chk("r_err_clear", 32'(o_err_cnt), 32'd0);
        wait_state(3'd6, "r_reach_done2");
        chk("r_pulses", 32'(pulses), 32'd16);
        chk("r_err_clean", 32'(o_err_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
